pulse_sequencer: RTL and testbench



---
 rtl/pulse_sequencer_pkg.sv | 32 +++
 rtl/pulse_sequencer_fifo.sv | 69 ++++++
 rtl/pulse_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pulse_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sequencer_pkg.sv
// Shared types and descriptor layout for the pulse sequencer.
// The optional status block is enabled by defining PULSE_SEQUENCER_STATUS_EN.
package pulse_sequencer_pkg;

    localparam int DESC_WIDTH  = 128;
    localparam int FIELD_WIDTH = 32;

    localparam int RISE_LSB    = 0;
    localparam int FALL_LSB    = 32;
    localparam int PERIOD_LSB  = 64;
    localparam int REP_LSB     = 96;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [FIELD_WIDTH-1:0] desc_field(
        input logic [DESC_WIDTH-1:0] desc,
        input int                    lsb
    );
        return desc[lsb +: FIELD_WIDTH];
    endfunction

    // A zero repeat count still plays the descriptor once.
    function automatic logic [FIELD_WIDTH-1:0] norm_repeats(
        input logic [FIELD_WIDTH-1:0] rep
    );
        return (rep == '0) ? FIELD_WIDTH'(1) : rep;
    endfunction

endpackage

// File: rtl/pulse_sequencer_fifo.sv
// First-word-fall-through descriptor FIFO: the head entry is visible on
// rd_data_o whenever empty_o is low, and rd_en_i consumes it.
module pulse_sequencer_fifo #(
    parameter int WIDTH      = 128,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  do_wr;
    logic                  do_rd;

    // Full/empty come from the registered count, so a pop while full does
    // not reopen the write port until the following cycle.
    assign full_o  = (count_q == (ADDR_WIDTH+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_wr   = wr_en_i && !full_o;
    assign do_rd   = rd_en_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule

// File: rtl/pulse_sequencer.sv
// Plays buffered pulse descriptors back-to-back through a rise/fall/period
// timing engine. Define PULSE_SEQUENCER_STATUS_EN for done/underrun status.
module pulse_sequencer
    import pulse_sequencer_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       run,
    input  logic [DESC_WIDTH-1:0]      s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       dout,
    output logic                       busy,
`ifdef PULSE_SEQUENCER_STATUS_EN
    output logic [31:0]                sts_done,
    output logic                       sts_underrun,
`endif
    output logic [FIFO_ADDR_WIDTH:0]   fifo_count
);

    logic [DESC_WIDTH-1:0]  head_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;

    state_e                 state_q;
    logic [FIELD_WIDTH-1:0] rise_q;
    logic [FIELD_WIDTH-1:0] fall_q;
    logic [FIELD_WIDTH-1:0] period_q;
    logic [FIELD_WIDTH-1:0] rep_q;
    logic [FIELD_WIDTH-1:0] cnt_q;
    logic                   dout_q;
    logic                   busy_q;

    logic                   wrap;
    logic                   last_period;

    pulse_sequencer_fifo #(
        .WIDTH      (DESC_WIDTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .wr_en_i    (s_axis_tvalid),
        .wr_data_i  (s_axis_tdata),
        .rd_en_i    (pop),
        .rd_data_o  (head_data),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign s_axis_tready = !fifo_full;

    assign wrap        = (cnt_q == period_q);
    assign last_period = (state_q == RUN) && wrap && (rep_q == FIELD_WIDTH'(1));

    // The next descriptor is taken either from idle or exactly on the final
    // wrap of the current one, which is what removes gap cycles.
    assign pop = run && !fifo_empty && ((state_q == IDLE) || last_period);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            rise_q   <= '0;
            fall_q   <= '0;
            period_q <= '0;
            rep_q    <= '0;
            cnt_q    <= '0;
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    dout_q <= 1'b0;
                    if (pop) begin
                        rise_q   <= desc_field(head_data, RISE_LSB);
                        fall_q   <= desc_field(head_data, FALL_LSB);
                        period_q <= desc_field(head_data, PERIOD_LSB);
                        rep_q    <= norm_repeats(desc_field(head_data, REP_LSB));
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                    end
                end

                RUN: begin
                    // Fall has priority so rise==fall never produces a pulse.
                    if (cnt_q == fall_q) begin
                        dout_q <= 1'b0;
                    end else if (cnt_q == rise_q) begin
                        dout_q <= 1'b1;
                    end

                    if (wrap) begin
                        cnt_q <= '0;
                        rep_q <= rep_q - FIELD_WIDTH'(1);
                        if (rep_q == FIELD_WIDTH'(1)) begin
                            if (pop) begin
                                rise_q   <= desc_field(head_data, RISE_LSB);
                                fall_q   <= desc_field(head_data, FALL_LSB);
                                period_q <= desc_field(head_data, PERIOD_LSB);
                                rep_q    <= norm_repeats(desc_field(head_data, REP_LSB));
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                dout_q  <= 1'b0;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + FIELD_WIDTH'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dout_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;

`ifdef PULSE_SEQUENCER_STATUS_EN
    logic [31:0] done_q;
    logic [31:0] done_d;
    logic        underrun_q;
    logic        underrun_d;

    // Every final-period wrap completes a descriptor; an empty FIFO there
    // while run is high means the stream fell behind.
    always_comb begin
        done_d     = done_q;
        underrun_d = underrun_q;
        if (last_period) begin
            done_d = done_q + 32'd1;
            if (run && fifo_empty) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            done_q     <= '0;
            underrun_q <= 1'b0;
        end else begin
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign sts_done     = done_q;
    assign sts_underrun = underrun_q;
`endif

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench: directed descriptor table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_pulse_sequencer;

    logic         aclk;
    logic         aresetn;
    logic         run;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         dout;
    logic         busy;
    logic [4:0]   fifo_count;
`ifdef PULSE_SEQUENCER_STATUS_EN
    logic [31:0]  sts_done;
    logic         sts_underrun;
`endif

    int checks   = 0;
    int failures = 0;

    pulse_sequencer #(.FIFO_ADDR_WIDTH(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .run           (run),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .dout          (dout),
        .busy          (busy),
`ifdef PULSE_SEQUENCER_STATUS_EN
        .sts_done      (sts_done),
        .sts_underrun  (sts_underrun),
`endif
        .fifo_count    (fifo_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference model: queue of pending descriptors plus elapsed time in the
    // active descriptor; counter position is derived arithmetically.
    logic [127:0] mq[$];
    bit           m_act;
    logic [127:0] m_cur;
    longint       m_t;
    bit           m_dout;
    int unsigned  m_done;
    bit           m_und;

    function automatic logic [127:0] mk(input int unsigned r, input int unsigned f,
                                        input int unsigned p, input int unsigned n);
        return {n, p, f, r};
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int     sz;
        bit     acc;
        bit     pop;
        longint per;
        longint reps;
        longint pos;
        bit     last;
        if (!aresetn) begin
            mq.delete();
            m_act = 0; m_t = 0; m_dout = 0; m_done = 0; m_und = 0;
            return;
        end
        sz  = mq.size();
        acc = s_axis_tvalid && (sz < 16);
        pop = 0;
        if (m_act) begin
            per  = longint'(m_cur[95:64]) + 1;
            reps = (m_cur[127:96] == 0) ? 1 : longint'(m_cur[127:96]);
            pos  = m_t % per;
            last = (m_t == per * reps - 1);
            if (pos == longint'(m_cur[63:32]))      m_dout = 0;
            else if (pos == longint'(m_cur[31:0]))  m_dout = 1;
            if (last) begin
                m_done++;
                if (run && sz > 0) pop = 1;
                else begin
                    if (run) m_und = 1;
                    m_dout = 0;
                    m_act  = 0;
                end
            end else begin
                m_t++;
            end
        end else begin
            m_dout = 0;
            if (run && sz > 0) pop = 1;
        end
        if (pop) begin
            m_cur = mq.pop_front();
            m_act = 1;
            m_t   = 0;
        end
        if (acc) mq.push_back(s_axis_tdata);
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic step();
        model_step();
        @(posedge aclk);
        #1;
        check("dout", dout, m_dout);
        check("busy", busy, m_act);
        check("fifo_count", fifo_count, mq.size());
        check("tready", s_axis_tready, mq.size() < 16);
`ifdef PULSE_SEQUENCER_STATUS_EN
        check("sts_done", sts_done, m_done);
        check("sts_underrun", sts_underrun, m_und);
`endif
    endtask

    task automatic do_reset();
        aresetn = 0; run = 0; s_axis_tvalid = 0; s_axis_tdata = '0;
        step();
        step();
        aresetn = 1;
    endtask

    task automatic push(input logic [127:0] d);
        s_axis_tvalid = 1; s_axis_tdata = d;
        step();
        s_axis_tvalid = 0;
    endtask

    typedef struct {
        int unsigned rise, fall, period, rep;
        int exp_high;
        int exp_busy;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int hi, bz, first, lastb;
        aresetn = 0; run = 0; s_axis_tvalid = 0; s_axis_tdata = '0;

        vecs[0] = '{rise:2, fall:5,  period:9, rep:3, exp_high:9,  exp_busy:30};
        vecs[1] = '{rise:3, fall:3,  period:7, rep:0, exp_high:0,  exp_busy:8};
        vecs[2] = '{rise:0, fall:1,  period:0, rep:4, exp_high:3,  exp_busy:4};
        vecs[3] = '{rise:1, fall:3,  period:4, rep:2, exp_high:4,  exp_busy:10};
        vecs[4] = '{rise:5, fall:20, period:9, rep:2, exp_high:14, exp_busy:20};

        do_reset();
        check("reset_dout", dout, 0);
        check("reset_busy", busy, 0);
        check("reset_count", fifo_count, 0);
        check("reset_tready", s_axis_tready, 1);

        // Directed single-descriptor table.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            push(mk(vecs[v].rise, vecs[v].fall, vecs[v].period, vecs[v].rep));
            run = 1;
            hi = 0; bz = 0;
            for (int c = 0; c < vecs[v].exp_busy + 6; c++) begin
                step();
                if (dout) hi++;
                if (busy) bz++;
            end
            $display("vec %0d: high=%0d busy=%0d", v, hi, bz);
            check("vec_high", hi, vecs[v].exp_high);
            check("vec_busy", bz, vecs[v].exp_busy);
            check("vec_end_busy", busy, 0);
            check("vec_end_dout", dout, 0);
        end

        // Back-to-back descriptors: busy must stay high with no gap.
        do_reset();
        push(mk(1, 3, 4, 2));
        push(mk(0, 2, 2, 1));
        run = 1;
        bz = 0; first = -1; lastb = -1;
        for (int c = 0; c < 25; c++) begin
            step();
            if (busy) begin
                bz++;
                if (first < 0) first = c;
                lastb = c;
            end
        end
        $display("b2b: busy=%0d span=%0d", bz, lastb - first + 1);
        check("b2b_busy", bz, 13);
        check("b2b_span", lastb - first + 1, 13);

        // Fill to full with run low, then release one slot.
        do_reset();
        s_axis_tvalid = 1;
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata = mk(1, 2, 3, 1 + i);
            step();
        end
        $display("full: count=%0d tready=%0d", fifo_count, s_axis_tready);
        check("full_count", fifo_count, 16);
        check("full_tready", s_axis_tready, 0);
        s_axis_tdata = mk(0, 1, 1, 1);
        step();
        check("full_blocked", fifo_count, 16);
        run = 1;
        step();
        check("full_pop", fifo_count, 15);
        run = 0;
        step();
        check("full_17th", fifo_count, 16);
        s_axis_tvalid = 0;

        // run drops during rep 2 of 4: descriptor completes, FIFO retained.
        do_reset();
        push(mk(0, 1, 3, 4));
        push(mk(1, 2, 3, 1));
        run = 1;
        bz = 0;
        for (int c = 0; c < 6; c++) begin step(); if (busy) bz++; end
        run = 0;
        for (int c = 0; c < 20; c++) begin step(); if (busy) bz++; end
        $display("runfall: busy=%0d count=%0d", bz, fifo_count);
        check("runfall_busy", bz, 16);
        check("runfall_count", fifo_count, 1);
`ifdef PULSE_SEQUENCER_STATUS_EN
        check("runfall_done", sts_done, 1);
        check("runfall_underrun", sts_underrun, 0);
`endif

        // Reset mid-run with 5 buffered descriptors.
        do_reset();
        for (int i = 0; i < 6; i++) push(mk(1, 2, 5, 3));
        run = 1;
        for (int c = 0; c < 3; c++) step();
        check("midrst_pre_dout", dout, 1);
        check("midrst_pre_count", fifo_count, 5);
        aresetn = 0;
        step();
        $display("midrst: dout=%0d busy=%0d count=%0d", dout, busy, fifo_count);
        check("midrst_dout", dout, 0);
        check("midrst_busy", busy, 0);
        check("midrst_count", fifo_count, 0);
        aresetn = 1; run = 0;
        push(mk(0, 1, 1, 1));
        run = 1;
        for (int c = 0; c < 6; c++) step();
`ifdef PULSE_SEQUENCER_STATUS_EN
        check("underrun_set", sts_underrun, 1);
        check("underrun_done", sts_done, 1);
`endif
        check("underrun_idle", busy, 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            aresetn       = ($urandom_range(0, 999) != 0);
            run           = ($urandom_range(0, 7) != 0);
            s_axis_tvalid = ($urandom_range(0, 2) == 0);
            s_axis_tdata  = mk($urandom_range(0, 7), $urandom_range(0, 7),
                               $urandom_range(0, 6), $urandom_range(0, 3));
            step();
        end
        aresetn = 1; s_axis_tvalid = 0; run = 0;
        $display("random: done, checks so far=%0d", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
